// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end: opcode encoding, flag bit positions
// and wrap-around opcode stepping helpers.
package alu_pkg;

  localparam int OP_COUNT = 10;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_LSR    = 4'd5,
    OP_LSL    = 4'd6,
    OP_MOD    = 4'd7,
    OP_PASS_A = 4'd8,
    OP_DIV    = 4'd9
  } opcode_e;

  // Bit positions inside the packed {v,c,n,z} flag vector.
  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  function automatic logic [3:0] op_step_up(input logic [3:0] op, input logic [3:0] op_last);
    return (op >= op_last) ? 4'd0 : op + 4'd1;
  endfunction

  function automatic logic [3:0] op_step_down(input logic [3:0] op, input logic [3:0] op_last);
    return (op == 4'd0) ? op_last : op - 4'd1;
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Synchronises a raw active-low button, debounces it and emits a single-cycle
// pulse when the accepted level goes from released to pressed.
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta_q;
  logic             sync_q;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (sync_q == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      state_d = sync_q;
      cnt_d   = '0;
      pulse_d = ~sync_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta_q <= 1'b1;
      sync_q      <= 1'b1;
      state_q     <= 1'b1;
      cnt_q       <= '0;
      pulse_q     <= 1'b0;
    end else begin
      sync_meta_q <= btn_n;
      sync_q      <= sync_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pulse_q     <= pulse_d;
    end
  end

  assign pressed_pulse = pulse_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Front-end stage for the ALU: debounced opcode stepping, operand switch
// synchronisers and registered result/flags for the displays.
module alu_op_sequencer #(
  parameter int N               = 4,
  parameter int OP_COUNT        = alu_pkg::OP_COUNT,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_inc_n,
  input  logic         btn_dec_n,
  input  logic [N-1:0] a_sw,
  input  logic [N-1:0] b_sw,
  input  logic [N-1:0] alu_result,
  input  logic         alu_v,
  input  logic         alu_c,
  input  logic         alu_n,
  input  logic         alu_z,
  output logic [3:0]   control,
  output logic [N-1:0] a_q,
  output logic [N-1:0] b_q,
  output logic [N-1:0] result_q,
  output logic [3:0]   flags_q,
  output logic         op_changed
);

  import alu_pkg::*;

  localparam logic [3:0] OP_LAST = 4'(OP_COUNT - 1);

  logic inc_pulse;
  logic dec_pulse;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_inc_debouncer (
    .clk          (clk),
    .rst          (rst),
    .btn_n        (btn_inc_n),
    .pressed_pulse(inc_pulse)
  );

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dec_debouncer (
    .clk          (clk),
    .rst          (rst),
    .btn_n        (btn_dec_n),
    .pressed_pulse(dec_pulse)
  );

  logic [3:0]   control_q, control_d;
  logic         op_changed_q, op_changed_d;
  logic [N-1:0] a_meta_q, a_sync_q;
  logic [N-1:0] b_meta_q, b_sync_q;
  logic [N-1:0] alu_result_q;
  logic [3:0]   alu_flags_q, alu_flags_d;

  // Simultaneous inc and dec presses cancel out.
  always_comb begin
    control_d = control_q;
    unique case ({inc_pulse, dec_pulse})
      2'b10:   control_d = op_step_up(control_q, OP_LAST);
      2'b01:   control_d = op_step_down(control_q, OP_LAST);
      default: control_d = control_q;
    endcase
    op_changed_d = (control_d != control_q);
  end

  always_comb begin
    alu_flags_d         = '0;
    alu_flags_d[FLAG_V] = alu_v;
    alu_flags_d[FLAG_C] = alu_c;
    alu_flags_d[FLAG_N] = alu_n;
    alu_flags_d[FLAG_Z] = alu_z;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      control_q    <= OP_ADD;
      op_changed_q <= 1'b0;
      a_meta_q     <= '0;
      a_sync_q     <= '0;
      b_meta_q     <= '0;
      b_sync_q     <= '0;
      alu_result_q <= '0;
      alu_flags_q  <= '0;
    end else begin
      control_q    <= control_d;
      op_changed_q <= op_changed_d;
      a_meta_q     <= a_sw;
      a_sync_q     <= a_meta_q;
      b_meta_q     <= b_sw;
      b_sync_q     <= b_meta_q;
      alu_result_q <= alu_result;
      alu_flags_q  <= alu_flags_d;
    end
  end

  assign control    = control_q;
  assign op_changed = op_changed_q;
  assign a_q        = a_sync_q;
  assign b_q        = b_sync_q;
  assign result_q   = alu_result_q;
  assign flags_q    = alu_flags_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a cycle-level reference model and
// a per-cycle compare, plus literal expectations at key points.
module tb_alu_op_sequencer;

  localparam int N   = 4;
  localparam int OPC = 10;
  localparam int D   = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         btn_inc_n, btn_dec_n;
  logic [N-1:0] a_sw, b_sw;
  logic [N-1:0] alu_result;
  logic         alu_v, alu_c, alu_n, alu_z;
  logic [3:0]   control;
  logic [N-1:0] a_q, b_q, result_q;
  logic [3:0]   flags_q;
  logic         op_changed;
  logic         ovr;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .N(N), .OP_COUNT(OPC), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_inc_n(btn_inc_n), .btn_dec_n(btn_dec_n),
    .a_sw(a_sw), .b_sw(b_sw),
    .alu_result(alu_result),
    .alu_v(alu_v), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z),
    .control(control), .a_q(a_q), .b_q(b_q),
    .result_q(result_q), .flags_q(flags_q), .op_changed(op_changed)
  );

  // Stand-in combinational ALU: returns {v,c,n,z,result}.
  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [3:0] a,
                                        input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic       c;
    s = 5'd0;
    c = 1'b0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; end
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      default: r = a;
    endcase
    return {1'b0, c, r[3], 1'b0, r};
  endfunction

  assign {alu_v, alu_c, alu_n, alu_z, alu_result} = ovr ? 8'hA8 : alu_fn(control, a_q, b_q);

  // Reference model: a button level is accepted once the synchronised level
  // has differed from the accepted one for D consecutive samples.
  logic [D:0] m_inc_hist, m_dec_hist;
  logic       m_inc_db, m_dec_db, m_inc_pend, m_dec_pend;
  logic       m_inc_press, m_dec_press, m_inc_rel, m_dec_rel;
  int         m_ctl;
  logic       m_chg;
  logic [3:0] m_ameta, m_a, m_bmeta, m_b, m_res, m_flg;
  logic       m_valid = 1'b0;

  assign m_inc_press = m_inc_db && (m_inc_hist[D:1] == '0);
  assign m_dec_press = m_dec_db && (m_dec_hist[D:1] == '0);
  assign m_inc_rel   = !m_inc_db && (&m_inc_hist[D:1]);
  assign m_dec_rel   = !m_dec_db && (&m_dec_hist[D:1]);

  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (rst) begin
      m_inc_hist <= '1;
      m_dec_hist <= '1;
      m_inc_db   <= 1'b1;
      m_dec_db   <= 1'b1;
      m_inc_pend <= 1'b0;
      m_dec_pend <= 1'b0;
      m_ctl      <= 0;
      m_chg      <= 1'b0;
      m_ameta    <= '0;
      m_a        <= '0;
      m_bmeta    <= '0;
      m_b        <= '0;
      m_res      <= '0;
      m_flg      <= '0;
    end else begin
      m_inc_hist <= {m_inc_hist[D-1:0], btn_inc_n};
      m_dec_hist <= {m_dec_hist[D-1:0], btn_dec_n};
      if (m_inc_press) m_inc_db <= 1'b0;
      else if (m_inc_rel) m_inc_db <= 1'b1;
      if (m_dec_press) m_dec_db <= 1'b0;
      else if (m_dec_rel) m_dec_db <= 1'b1;
      m_inc_pend <= m_inc_press;
      m_dec_pend <= m_dec_press;
      m_chg      <= m_inc_pend ^ m_dec_pend;
      if (m_inc_pend && !m_dec_pend) m_ctl <= (m_ctl + 1) % OPC;
      else if (m_dec_pend && !m_inc_pend) m_ctl <= (m_ctl + OPC - 1) % OPC;
      m_ameta <= a_sw;
      m_a     <= m_ameta;
      m_bmeta <= b_sw;
      m_b     <= m_bmeta;
      {m_flg, m_res} <= ovr ? 8'hA8 : alu_fn(4'(m_ctl), m_a, m_b);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("control",    32'(control),    32'(m_ctl));
      check("op_changed", 32'(op_changed), 32'(m_chg));
      check("a_q",        32'(a_q),        32'(m_a));
      check("b_q",        32'(b_q),        32'(m_b));
      check("result_q",   32'(result_q),   32'(m_res));
      check("flags_q",    32'(flags_q),    32'(m_flg));
      if (op_changed === 1'b1) pulse_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press(input logic inc, input logic dec, input int hold);
    btn_inc_n = !inc;
    btn_dec_n = !dec;
    tick(hold);
    btn_inc_n = 1'b1;
    btn_dec_n = 1'b1;
    tick(10);
  endtask

  initial begin
    rst = 1'b1;
    btn_inc_n = 1'b1;
    btn_dec_n = 1'b1;
    a_sw = '0;
    b_sw = '0;
    ovr = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(20);
    check("idle_control", 32'(control), 32'd0);
    check("idle_result",  32'(result_q), 32'd0);
    check("idle_flags",   32'(flags_q), 32'd0);
    check("idle_pulses",  32'(pulse_cnt), 32'd0);

    // Long hold: exactly one step, no auto-repeat.
    btn_inc_n = 1'b0;
    tick(10);
    check("held_control", 32'(control), 32'd1);
    check("held_pulses",  32'(pulse_cnt), 32'd1);
    btn_inc_n = 1'b1;
    tick(10);
    check("released_control", 32'(control), 32'd1);
    check("released_pulses",  32'(pulse_cnt), 32'd1);

    for (int i = 0; i < 9; i++) press(1'b1, 1'b0, 8);
    check("wrap_to_zero", 32'(control), 32'd0);

    for (int k = 1; k <= 10; k++) begin
      press(1'b1, 1'b0, 8);
      check("inc_sequence", 32'(control), 32'(k % 10));
    end
    press(1'b0, 1'b1, 8);
    check("dec_wrap", 32'(control), 32'd9);
    check("pulses_after_steps", 32'(pulse_cnt), 32'd21);

    // Short bounces are rejected.
    for (int i = 0; i < 5; i++) begin
      btn_inc_n = 1'b0;
      tick(2);
      btn_inc_n = 1'b1;
      tick(2);
    end
    tick(8);
    check("glitch_control", 32'(control), 32'd9);
    check("glitch_pulses",  32'(pulse_cnt), 32'd21);

    press(1'b1, 1'b1, 8);
    check("both_control", 32'(control), 32'd9);
    check("both_pulses",  32'(pulse_cnt), 32'd21);

    a_sw = 4'h3;
    b_sw = 4'h5;
    ovr  = 1'b1;
    tick(2);
    check("a_q_latency", 32'(a_q), 32'd3);
    check("b_q_latency", 32'(b_q), 32'd5);
    tick(1);
    check("result_capture", 32'(result_q), 32'd8);
    check("flags_capture",  32'(flags_q), 32'hA);

    // Reset in the middle of a press discards everything.
    btn_inc_n = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(1);
    check("rst_control",    32'(control), 32'd0);
    check("rst_op_changed", 32'(op_changed), 32'd0);
    check("rst_a_q",        32'(a_q), 32'd0);
    check("rst_b_q",        32'(b_q), 32'd0);
    check("rst_result",     32'(result_q), 32'd0);
    check("rst_flags",      32'(flags_q), 32'd0);
    rst = 1'b0;
    tick(10);
    check("held_through_reset", 32'(control), 32'd1);
    btn_inc_n = 1'b1;
    tick(10);
    ovr = 1'b0;
    tick(5);
    check("final_control", 32'(control), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
